wtr_burst_decoder: RTL and testbench

Parametrised successor to the processor's write-to-register (WTR) select decoder. It converts a binary register select into a registered one-hot write-enable vector. It also supports multi-register burst writes: a single request drives consecutive registers on consecutive cycles, with wrap-around. The block sits between the control unit and the datapath register bank, and drives each register's write-enable.

---
 rtl/wtr_burst_decoder.sv | 163 ++++++++++++++++
 tb/tb_wtr_burst_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wtr_burst_decoder.sv
// ---------------------------------------------------------------------------
// wtr_burst_decoder
//
// Purpose:
//   Turns a binary write-to-register select code into a registered one-hot
//   write-enable vector for the datapath register bank. A request can also
//   ask for a burst. A burst drives consecutive register codes on
//   consecutive cycles, wrapping from NUM_REGS back to 1.
//
// Parameters:
//   NUM_REGS  number of writable registers (valid codes 1..NUM_REGS)
//   SEL_W     select width, needs 2**SEL_W > NUM_REGS
//   LEN_W     burst-length width (extra registers after the start)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   wtr_sel     start register code
//   wtr_en      request strobe
//   burst_len   extra registers after the start (0 = single write)
//   wtr_onehot  registered write enables, bit k -> register code k+1
//   busy        high while a burst still has enables left after this one
//   done        pulse on the final enable of an accepted request
//   req_err     pulse one cycle after a rejected request
//   wr_count    (only with WTR_WRITE_COUNT_EN) saturating count of cycles
//               with any enable asserted
//
// Build option:
//   WTR_WRITE_COUNT_EN  adds the wr_count output and its counter.
// ---------------------------------------------------------------------------
module wtr_burst_decoder #(
  parameter int NUM_REGS = 14,
  parameter int SEL_W    = 5,
  parameter int LEN_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SEL_W-1:0]    wtr_sel,
  input  logic                wtr_en,
  input  logic [LEN_W-1:0]    burst_len,
  output logic [NUM_REGS-1:0] wtr_onehot,
  output logic                busy,
  output logic                done,
`ifdef WTR_WRITE_COUNT_EN
  output logic [15:0]         wr_count,
`endif
  output logic                req_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_reg;
  logic [SEL_W-1:0]    cur_sel_reg;
  logic [LEN_W-1:0]    remaining_reg;
  logic [NUM_REGS-1:0] onehot_reg;
  logic                done_reg;
  logic                req_err_reg;

  // A request is valid only for codes 1..NUM_REGS. Code 0 means no write.
  logic                sel_valid;
  // This is the next code in a burst. Code 0 is skipped on wrap.
  logic [SEL_W-1:0]    adv_sel;
  logic [NUM_REGS-1:0] req_dec;
  logic [NUM_REGS-1:0] adv_dec;

  assign sel_valid = (wtr_sel != '0) && (wtr_sel <= SEL_W'(NUM_REGS));
  assign adv_sel   = (cur_sel_reg == SEL_W'(NUM_REGS)) ? SEL_W'(1)
                                                       : cur_sel_reg + SEL_W'(1);

  // Each decoder compares against a single code, so both vectors stay
  // one-hot or zero by construction.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign req_dec[gi] = (wtr_sel == SEL_W'(gi + 1));
      assign adv_dec[gi] = (adv_sel == SEL_W'(gi + 1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_sel_reg   <= '0;
      remaining_reg <= '0;
      onehot_reg    <= '0;
      done_reg      <= 1'b0;
      req_err_reg   <= 1'b0;
    end else begin
      // The pulses and enables default to idle. Each branch below only
      // raises the ones that apply.
      onehot_reg  <= '0;
      done_reg    <= 1'b0;
      req_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (wtr_en) begin
            if (sel_valid) begin
              onehot_reg  <= req_dec;
              cur_sel_reg <= wtr_sel;
              if (burst_len == '0) begin
                // A single write ends here. Stay in IDLE so a new
                // request can be taken on every cycle.
                done_reg <= 1'b1;
              end else begin
                state_reg     <= BURST;
                remaining_reg <= burst_len;
              end
            end else begin
              req_err_reg <= 1'b1;
            end
          end
        end

        BURST: begin
          onehot_reg    <= adv_dec;
          cur_sel_reg   <= adv_sel;
          remaining_reg <= remaining_reg - LEN_W'(1);
          // When one enable is left, that enable is the final one. The
          // state goes back to IDLE on the same edge, so busy is already
          // low on the final-enable cycle and a new request can be taken.
          if (remaining_reg == LEN_W'(1)) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
          // A request during a burst is rejected. The burst carries on.
          if (wtr_en) begin
            req_err_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign wtr_onehot = onehot_reg;
  assign busy       = (state_reg == BURST);
  assign done       = done_reg;
  assign req_err    = req_err_reg;

`ifdef WTR_WRITE_COUNT_EN
  logic [15:0] wr_count_reg;

  // This counts every cycle on which any enable is visible. It holds at
  // all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_reg <= '0;
    end else if ((|onehot_reg) && (wr_count_reg != 16'hFFFF)) begin
      wr_count_reg <= wr_count_reg + 16'd1;
    end
  end

  assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_wtr_burst_decoder.sv
module tb_wtr_burst_decoder;

  localparam int NUM_REGS = 14;
  localparam int SEL_W    = 5;
  localparam int LEN_W    = 4;

  logic                clk;
  logic                rst;
  logic [SEL_W-1:0]    wtr_sel;
  logic                wtr_en;
  logic [LEN_W-1:0]    burst_len;
  logic [NUM_REGS-1:0] wtr_onehot;
  logic                busy;
  logic                done;
  logic                req_err;
`ifdef WTR_WRITE_COUNT_EN
  logic [15:0]         wr_count;
`endif

  wtr_burst_decoder #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .LEN_W    (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wtr_sel    (wtr_sel),
    .wtr_en     (wtr_en),
    .burst_len  (burst_len),
    .wtr_onehot (wtr_onehot),
    .busy       (busy),
    .done       (done),
`ifdef WTR_WRITE_COUNT_EN
    .wr_count   (wr_count),
`endif
    .req_err    (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_REGS-1:0] oh;
    logic                b;
    logic                d;
    logic                e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;

  // Converts a register code to its expected one-hot value. It is built
  // from the code alone, independent of the DUT.
  function automatic logic [NUM_REGS-1:0] code_oh(input int code);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (code >= 1 && code <= NUM_REGS) v[code-1] = 1'b1;
    return v;
  endfunction

  // This drives one cycle of stimulus and queues the outputs expected after
  // the next rising edge. Just after that edge, it pops the expectation and
  // compares it with the DUT outputs.
  task automatic cyc(input string tag, input logic r, input logic en,
                     input int sel, input int len,
                     input logic [NUM_REGS-1:0] e_oh, input logic e_b,
                     input logic e_d, input logic e_e);
    exp_t ex;
    rst       = r;
    wtr_en    = en;
    wtr_sel   = SEL_W'(sel);
    burst_len = LEN_W'(len);
    exp_q.push_back('{oh: e_oh, b: e_b, d: e_d, e: e_e});
    @(posedge clk);
    #1;
    cycle_no++;
    ex = exp_q.pop_front();
    $display("cyc %0d %s: en=%0b sel=%0d len=%0d -> onehot=%h busy=%0b done=%0b req_err=%0b",
             cycle_no, tag, en, sel, len, wtr_onehot, busy, done, req_err);
    checks++;
    assert (wtr_onehot === ex.oh) else begin
      errors++;
      $error("FAIL %s onehot: got %h expected %h", tag, wtr_onehot, ex.oh);
    end
    checks++;
    assert (busy === ex.b) else begin
      errors++;
      $error("FAIL %s busy: got %0b expected %0b", tag, busy, ex.b);
    end
    checks++;
    assert (done === ex.d) else begin
      errors++;
      $error("FAIL %s done: got %0b expected %0b", tag, done, ex.d);
    end
    checks++;
    assert (req_err === ex.e) else begin
      errors++;
      $error("FAIL %s req_err: got %0b expected %0b", tag, req_err, ex.e);
    end
    checks++;
    assert ($countones(wtr_onehot) <= 1) else begin
      errors++;
      $error("FAIL %s onehot_inv: got %h expected at most one bit", tag, wtr_onehot);
    end
  endtask

  initial begin
    rst = 1'b1; wtr_en = 1'b0; wtr_sel = '0; burst_len = '0;

    // Check the reset state.
    cyc("reset",   1, 0, 0, 0, '0, 0, 0, 0);
    cyc("reset2",  1, 1, 3, 0, '0, 0, 0, 0);

    // Check a single write to code 3.
    cyc("single3", 0, 1, 3, 0, 14'h0004, 0, 1, 0);
    cyc("idle1",   0, 0, 0, 0, '0, 0, 0, 0);

    // Check back-to-back single writes.
    cyc("b2b_1",   0, 1, 1, 0, 14'h0001, 0, 1, 0);
    cyc("b2b_2",   0, 1, 2, 0, 14'h0002, 0, 1, 0);
    cyc("b2b_14",  0, 1, 14, 0, 14'h2000, 0, 1, 0);
    cyc("idle2",   0, 0, 0, 0, '0, 0, 0, 0);

    // Check a burst from 13 with length 3 that wraps past 14.
    cyc("wr13",    0, 1, 13, 3, 14'h1000, 1, 0, 0);
    cyc("wr14",    0, 0, 0, 0, 14'h2000, 1, 0, 0);
    cyc("wr1",     0, 0, 0, 0, 14'h0001, 1, 0, 0);
    cyc("wr2",     0, 0, 0, 0, 14'h0002, 0, 1, 0);
    cyc("idle3",   0, 0, 0, 0, '0, 0, 0, 0);

    // Reject a request mid-burst, then accept one at the final-enable edge.
    cyc("bu5",     0, 1, 5, 4, code_oh(5), 1, 0, 0);
    cyc("bu6_rej", 0, 1, 9, 0, code_oh(6), 1, 0, 1);
    cyc("bu7",     0, 0, 0, 0, code_oh(7), 1, 0, 0);
    cyc("bu8",     0, 0, 0, 0, code_oh(8), 1, 0, 0);
    cyc("bu9",     0, 0, 0, 0, code_oh(9), 0, 1, 0);
    cyc("acc9",    0, 1, 9, 0, code_oh(9), 0, 1, 0);
    cyc("idle4",   0, 0, 0, 0, '0, 0, 0, 0);

    // Reject invalid select codes.
    cyc("sel0",    0, 1, 0, 0, '0, 0, 0, 1);
    cyc("sel15",   0, 1, 15, 0, '0, 0, 0, 1);
    cyc("sel31b",  0, 1, 31, 2, '0, 0, 0, 1);
    cyc("idle5",   0, 0, 0, 0, '0, 0, 0, 0);

    // Check a long burst with burst_len >= NUM_REGS: 16 enables from 14.
    cyc("long0",   0, 1, 14, 15, code_oh(14), 1, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      cyc("long", 0, 0, 0, 0, code_oh(((13 + i) % NUM_REGS) + 1),
          (i < 15), (i == 15), 0);
    end
    cyc("idle6",   0, 0, 0, 0, '0, 0, 0, 0);

`ifdef WTR_WRITE_COUNT_EN
    // The enabled-cycle count up to here is 1+3+4+5+1+16 = 30.
    checks++;
    assert (wr_count === 16'd30) else begin
      errors++;
      $error("FAIL wr_count_pre: got %0d expected 30", wr_count);
    end
`endif

    // Reset on the third enable cycle of a burst from 2 with length 7.
    cyc("rb2",     0, 1, 2, 7, code_oh(2), 1, 0, 0);
    cyc("rb3",     0, 0, 0, 0, code_oh(3), 1, 0, 0);
    cyc("rb4",     0, 0, 0, 0, code_oh(4), 1, 0, 0);
    cyc("rb_rst",  1, 0, 0, 0, '0, 0, 0, 0);
`ifdef WTR_WRITE_COUNT_EN
    checks++;
    assert (wr_count === 16'd0) else begin
      errors++;
      $error("FAIL wr_count_rst: got %0d expected 0", wr_count);
    end
`endif
    cyc("post_rst", 0, 0, 0, 0, '0, 0, 0, 0);
    cyc("post_wr",  0, 1, 7, 0, code_oh(7), 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
